fifo_rd_stream: RTL and testbench
=================================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of FIFO read data and stream data.
REQ-002 SHALL have parameter PKT_LEN, default 16: beats per packet; legal range 1..65535.
REQ-003 SHALL have port wr_clk  input  1  single clock for all logic; rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port en  input  1  read enable; 0 blocks new FIFO reads.
REQ-006 SHALL have port fifo_empty  input  1  empty flag of the attached std-mode sync FIFO (read latency 1).
REQ-007 SHALL have port fifo_rd_rst_busy  input  1  FIFO read-side reset busy.
REQ-008 SHALL have port fifo_dout  input  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en.
REQ-009 SHALL have port fifo_rd_en  output  1  FIFO read request.
REQ-010 SHALL have port m_tdata  output  DATA_WIDTH  stream data.
REQ-011 SHALL have port m_tvalid  output  1  stream valid.
REQ-012 SHALL have port m_tready  input  1  stream ready from sink.
REQ-013 SHALL have port m_tlast  output  1  last beat of packet.
REQ-014 SHALL have port pkt_count  output  16  completed packets, wraps 65535->0.

Function
REQ-015 SHALL contain a 3-entry in-order output buffer (occ 0..3) and a 1-bit in-flight flag (infl) set in the cycle after a read is issued.
REQ-016 SHALL drive fifo_rd_en = !rst && en && !fifo_empty && !fifo_rd_rst_busy && (occ + infl < 3), with no combinational dependence on m_tready.
REQ-017 SHALL capture fifo_dout into the buffer tail at the wr_clk edge ending every cycle where infl=1.
REQ-018 SHALL drive m_tvalid = (occ != 0) and m_tdata = buffer head; m_tdata SHALL be 0 when occ = 0.
REQ-019 SHALL complete a beat when m_tvalid && m_tready, popping the head at that edge.
REQ-020 SHALL handle capture and pop in the same cycle with occ unchanged and order preserved.
REQ-021 SHALL hold m_tvalid, m_tdata and m_tlast stable while m_tvalid=1 and m_tready=0.
REQ-022 SHALL have latency of 2 cycles from fifo_rd_en assertion to that word on m_tdata with m_tvalid=1, given an empty buffer.
REQ-023 SHALL sustain one beat per cycle when fifo_empty=0, en=1 and m_tready=1 continuously.
REQ-024 SHALL keep a beat counter (0..PKT_LEN-1) that increments on each completed beat and wraps to 0 after PKT_LEN-1.
REQ-025 SHALL drive m_tlast = m_tvalid && (beat counter == PKT_LEN-1); PKT_LEN=1 asserts m_tlast on every beat.
REQ-026 SHALL increment pkt_count on each completed beat with m_tlast=1.
REQ-027 SHALL hold the beat counter when the buffer drains mid-packet and resume counting on refill.
REQ-028 SHALL, when en falls, issue no further reads from that cycle onward while still capturing in-flight data and delivering all buffered beats.
REQ-029 SHALL never let occ exceed 3; no word is lost or duplicated under any m_tready pattern.
REQ-030 SHALL assert fifo_rd_en only when fifo_empty is low in that cycle, so no FIFO underflow is ever caused.

Reset
REQ-031 SHALL, while rst=1, force occ=0, infl=0, beat counter=0, pkt_count=0, fifo_rd_en=0, m_tvalid=0, m_tlast=0 and m_tdata=0.
REQ-032 SHALL, on rst assertion mid-packet, discard buffered and in-flight words; the first beat after release starts a new packet at beat 0.
REQ-033 SHALL issue no read before the first wr_clk edge after rst deasserts, and none while fifo_rd_rst_busy=1.

Verification
REQ-034 SHALL cover reset: rst=1 with fifo_empty=0, m_tready=1 -> fifo_rd_en=0, m_tvalid=0, m_tdata=0, pkt_count=0 throughout.
REQ-035 SHALL cover streaming: FIFO holds 1..8, PKT_LEN=4, m_tready=1 -> m_tvalid 2 cycles after first fifo_rd_en, beats 1..8 back-to-back, m_tlast on 4 and 8, pkt_count=2.
REQ-036 SHALL cover backpressure: FIFO holds 1..8, m_tready=0 for 10 cycles -> exactly 3 reads issued, m_tdata=1 stable; on release beats 1..8 in order with no gap or loss.
REQ-037 SHALL cover underrun: PKT_LEN=4, 2 words, 5-cycle empty gap, 2 more -> m_tvalid drops after beat 2, m_tlast only on beat 4, pkt_count=1.
REQ-038 SHALL cover en: en dropped the cycle after a read with 2 buffered -> fifo_rd_en=0 at once, 3 further beats delivered, then m_tvalid=0.
REQ-039 SHALL cover mid-packet reset: rst pulsed after beat 2 of PKT_LEN=4 -> outputs 0, next packet m_tlast on its 4th beat, pkt_count=1.

Source files
------------

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus outgoing stream handshake, bundled for the reader block.
// master = the reader (drives rd_en and the stream), slave = FIFO/sink side.
interface fifo_rd_stream_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_empty;
    logic                  fifo_rd_rst_busy;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] m_tdata;
    logic                  m_tvalid;
    logic                  m_tready;
    logic                  m_tlast;

    modport master (
        input  fifo_empty, fifo_rd_rst_busy, fifo_dout, m_tready,
        output fifo_rd_en, m_tdata, m_tvalid, m_tlast
    );

    modport slave (
        output fifo_empty, fifo_rd_rst_busy, fifo_dout, m_tready,
        input  fifo_rd_en, m_tdata, m_tvalid, m_tlast
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Drains a latency-1 sync FIFO into a packetised valid/ready stream through a
// 3-deep skid buffer, so reads never depend combinationally on m_tready.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LEN    = 16
) (
    input  logic                 wr_clk,
    input  logic                 rst,
    input  logic                 en,
    fifo_rd_stream_if.master     bus,
    output logic [15:0]          pkt_count
);
    localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

    logic [DATA_WIDTH-1:0] obuf   [3];
    logic [DATA_WIDTH-1:0] obuf_n [3];
    logic [1:0]            occ, occ_n;
    logic                  infl;
    logic [15:0]           beat;
    logic [2:0]            fill;
    logic                  rd, pop;

    // A read is only launched when its word is guaranteed a free slot on arrival.
    assign fill = {1'b0, occ} + {2'b00, infl};
    assign rd   = !rst && en && !bus.fifo_empty && !bus.fifo_rd_rst_busy && (fill < 3'd3);

    assign bus.fifo_rd_en = rd;
    assign bus.m_tvalid   = (occ != 2'd0);
    assign bus.m_tdata    = bus.m_tvalid ? obuf[0] : '0;
    assign bus.m_tlast    = bus.m_tvalid && (beat == LAST_BEAT);
    assign pop            = bus.m_tvalid && bus.m_tready;

    // Head sits at index 0; pop shifts down before the arriving word lands at the tail.
    always_comb begin
        obuf_n = obuf;
        occ_n  = occ;
        if (pop) begin
            obuf_n[0] = obuf[1];
            obuf_n[1] = obuf[2];
            occ_n     = occ - 2'd1;
        end
        if (infl) begin
            case (occ_n)
                2'd0:    obuf_n[0] = bus.fifo_dout;
                2'd1:    obuf_n[1] = bus.fifo_dout;
                2'd2:    obuf_n[2] = bus.fifo_dout;
                default: ;
            endcase
            occ_n = occ_n + 2'd1;
        end
    end

    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            occ       <= '0;
            infl      <= 1'b0;
            beat      <= '0;
            pkt_count <= '0;
            for (int i = 0; i < 3; i++) obuf[i] <= '0;
        end else begin
            occ  <= occ_n;
            infl <= rd;
            obuf <= obuf_n;
            if (pop) begin
                beat <= (beat == LAST_BEAT) ? 16'd0 : beat + 16'd1;
                if (bus.m_tlast) pkt_count <= pkt_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed scenarios plus a random phase; a queue scoreboard predicts every beat.
module tb_fifo_rd_stream;
    localparam int PKT = 4;

    logic        wr_clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] pkt_count;

    fifo_rd_stream_if #(.DATA_WIDTH(32)) bus ();

    fifo_rd_stream #(.DATA_WIDTH(32), .PKT_LEN(PKT)) dut (
        .wr_clk    (wr_clk),
        .rst       (rst),
        .en        (en),
        .bus       (bus.master),
        .pkt_count (pkt_count)
    );

    always #5 wr_clk = ~wr_clk;

    logic [31:0] fq [$];
    logic [31:0] exp_q [$];
    int          n_chk = 0, n_err = 0;
    int          cyc = 0, cyc_s, beat_m = 0;
    logic [15:0] pkt_exp = 0;
    logic        rdd, vld_s, fired;
    logic        hold = 0, hold_l;
    logic [31:0] hold_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [31:0] v);
        fq.push_back(v);
        exp_q.push_back(v);
        bus.fifo_empty = 1'b0;
    endtask

    // One clock: check settled outputs, let the edge happen, then model the FIFO read.
    task automatic tick();
        logic [31:0] w;
        #1;
        rdd = bus.fifo_rd_en; vld_s = bus.m_tvalid; fired = 1'b0; cyc_s = cyc;
        if (rst) begin
            chk("rst_rd_en", {31'd0, rdd}, 0);
            chk("rst_tvalid", {31'd0, bus.m_tvalid}, 0);
            chk("rst_tdata", bus.m_tdata, 0);
            chk("rst_tlast", {31'd0, bus.m_tlast}, 0);
            chk("rst_pkt_count", {16'd0, pkt_count}, 0);
        end else begin
            if (rdd) chk("rd_when_empty", {31'd0, bus.fifo_empty}, 0);
            if (bus.fifo_rd_rst_busy) chk("rd_when_busy", {31'd0, rdd}, 0);
            chk("pkt_count", {16'd0, pkt_count}, {16'd0, pkt_exp});
            if (hold) begin
                chk("hold_tvalid", {31'd0, bus.m_tvalid}, 1);
                chk("hold_tdata", bus.m_tdata, hold_d);
                chk("hold_tlast", {31'd0, bus.m_tlast}, {31'd0, hold_l});
            end
            if (!bus.m_tvalid) begin
                chk("idle_tdata", bus.m_tdata, 0);
                chk("idle_tlast", {31'd0, bus.m_tlast}, 0);
            end else if (bus.m_tready) begin
                fired = 1'b1;
                chk("beat_expected", {31'd0, exp_q.size() > 0}, 1);
                if (exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    chk("beat_data", bus.m_tdata, w);
                    chk("beat_last", {31'd0, bus.m_tlast}, {31'd0, beat_m == PKT - 1});
                    if (beat_m == PKT - 1) pkt_exp = pkt_exp + 16'd1;
                    beat_m = (beat_m + 1) % PKT;
                end
            end
            hold   = bus.m_tvalid && !bus.m_tready;
            hold_d = bus.m_tdata;
            hold_l = bus.m_tlast;
        end
        @(posedge wr_clk);
        #1;
        if (rdd && fq.size() > 0) bus.fifo_dout = fq.pop_front();
        bus.fifo_empty = (fq.size() == 0);
        cyc++;
        @(negedge wr_clk);
    endtask

    task automatic rst_pulse(input int n);
        rst = 1'b1;
        fq.delete(); exp_q.delete();
        bus.fifo_empty = 1'b1;
        beat_m = 0; pkt_exp = 0; hold = 1'b0;
        for (int i = 0; i < n; i++) tick();
        rst = 1'b0;
    endtask

    task automatic drain(input int max);
        int k = 0;
        en = 1'b1; bus.m_tready = 1'b1; bus.fifo_rd_rst_busy = 1'b0;
        while (exp_q.size() > 0 && k < max) begin tick(); k++; end
        chk("drain_left", exp_q.size(), 0);
        tick(); tick();
    endtask

    initial begin
        int first_rd, first_v, first_b, last_b, nb, nrd;
        rst = 1'b1; en = 1'b1;
        bus.m_tready = 1'b1; bus.fifo_rd_rst_busy = 1'b0;
        bus.fifo_empty = 1'b1; bus.fifo_dout = '0;

        // reset held with a non-empty FIFO, then streaming 1..8
        for (int i = 1; i <= 8; i++) push(32'(i));
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        first_rd = -1; first_v = -1; first_b = 0; last_b = 0; nb = 0;
        for (int k = 0; k < 40 && nb < 8; k++) begin
            tick();
            if (rdd && first_rd < 0) first_rd = cyc_s;
            if (vld_s && first_v < 0) first_v = cyc_s;
            if (fired) begin if (nb == 0) first_b = cyc_s; last_b = cyc_s; nb++; end
        end
        chk("stream_latency", first_v - first_rd, 2);
        chk("stream_beats", nb, 8);
        chk("stream_span", last_b - first_b, 7);
        tick();
        chk("stream_pkts", {16'd0, pkt_count}, 2);

        // backpressure
        bus.m_tready = 1'b0;
        for (int i = 1; i <= 8; i++) push(32'(i));
        nrd = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (rdd) nrd++; end
        chk("bp_reads", nrd, 3);
        chk("bp_tdata", bus.m_tdata, 1);
        chk("bp_tvalid", {31'd0, bus.m_tvalid}, 1);
        bus.m_tready = 1'b1;
        nb = 0;
        for (int k = 0; k < 40 && nb < 8; k++) begin
            tick();
            if (fired) begin if (nb == 0) first_b = cyc_s; last_b = cyc_s; nb++; end
        end
        chk("bp_beats", nb, 8);
        chk("bp_span", last_b - first_b, 7);
        tick();
        chk("bp_pkts", {16'd0, pkt_count}, 4);

        // underrun mid-packet
        push(32'h21); push(32'h22);
        drain(20);
        for (int i = 0; i < 5; i++) begin tick(); chk("gap_tvalid", {31'd0, bus.m_tvalid}, 0); end
        push(32'h23); push(32'h24);
        drain(20);
        chk("underrun_pkts", {16'd0, pkt_count}, 5);

        // en dropped with the buffer filling
        bus.m_tready = 1'b0;
        for (int i = 0; i < 10; i++) push(32'h31 + 32'(i));
        for (int i = 0; i < 3; i++) tick();
        en = 1'b0;
        #1;
        chk("en_rd_en", {31'd0, bus.fifo_rd_en}, 0);
        bus.m_tready = 1'b1;
        nb = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (fired) nb++; chk("en_no_read", {31'd0, rdd}, 0); end
        chk("en_beats", nb, 3);
        chk("en_tvalid_end", {31'd0, bus.m_tvalid}, 0);
        drain(40);
        push(32'h41); push(32'h42);
        drain(20);

        // reset after beat 2 of a packet
        for (int i = 0; i < 8; i++) push(32'h61 + 32'(i));
        nb = 0;
        for (int k = 0; k < 40 && nb < 2; k++) begin tick(); if (fired) nb++; end
        chk("mid_beats", nb, 2);
        rst_pulse(2);
        for (int i = 0; i < 5; i++) push(32'h71 + 32'(i));
        drain(40);
        chk("rst_pkts", {16'd0, pkt_count}, 1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            bus.m_tready = ($urandom % 10) < 7;
            en = ($urandom % 10) != 0;
            bus.fifo_rd_rst_busy = ($urandom % 20) == 0;
            if ($urandom % 2) push($urandom);
            tick();
        end
        drain(200);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
